snn_img_loader: RTL



---
 rtl/snn_img_loader.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/snn_img_loader.sv
// snn_img_loader
// ---------------------------------------------------------------------------
// Host-side image sender for the SNN serial link. Reads a 1-bit-per-pixel
// image (8*NUM_BYTES pixels) from a bit-addressed memory and packs it
// LSB-first into bytes. Pixel 8k+i lands in bit i of byte k. Each byte is
// handed to a byte-level uart_tx. The block then waits for the single
// classification byte from uart_rx and holds the digit it reports.
//
// Optional feature macro: SNN_LOADER_TIMEOUT_EN
//   defined   : WAIT_RES gives up after TIMEOUT_CYCLES cycles, sets timeout
//               and ends the transaction with result unchanged.
//   undefined : WAIT_RES waits indefinitely and timeout is always 0.
//
// Ports
//   clk, rst    : clock and synchronous active-high reset
//   start       : one-cycle request; only accepted in IDLE
//   img_addr    : image memory bit address = 8*byte_cnt + bit_cnt
//   img_q       : image memory data, valid one cycle after img_addr
//   tx_start    : one-cycle pulse to uart_tx
//   tx_data     : byte to uart_tx, held from tx_start until tx_rdy returns
//   tx_rdy      : uart_tx idle
//   rx_rdy      : one-cycle pulse from uart_rx with rx_data valid
//   rx_data     : received byte
//   busy        : high from accepted start until the transaction ends
//   done        : one-cycle pulse when the transaction ends
//   result      : received digit, held until the next accepted start
//   result_err  : received byte was not a digit 0..9, held
//   timeout     : no reply in time, held until the next accepted start
//   dbg_state   : current FSM state
//
// Handshake: uart_tx accepts a byte in a cycle where tx_start=1 and
// tx_rdy=1; tx_start is only raised after tx_rdy was seen high, and tx_data
// stays put until tx_rdy is seen high again. rx_rdy is a one-cycle valid
// strobe with no back-pressure; it is only consumed in WAIT_RES.
// ---------------------------------------------------------------------------
module snn_img_loader #(
  parameter int NUM_BYTES      = 98,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] img_addr,
  input  logic              img_q,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_rdy,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              busy,
  output logic              done,
  output logic [3:0]        result,
  output logic              result_err,
  output logic              timeout,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_SEND     = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_WAIT_TX  = 3'd4,
    S_WAIT_RES = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);

  state_t      state_q, state_d;
  logic [6:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        lat_q, lat_d;        // extra fetch cycle for the last read
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  result_q, result_d;
  logic        result_err_q, result_err_d;
  logic        timeout_q, timeout_d;

`ifdef SNN_LOADER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // {byte_cnt, bit_cnt} is exactly 8*byte_cnt + bit_cnt.
  assign img_addr   = ADDR_W'({byte_cnt_q, bit_cnt_q});
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign result_err = result_err_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    lat_d        = lat_q;
    shreg_d      = shreg_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    result_d     = result_q;
    result_err_d = result_err_q;
    timeout_d    = timeout_q;
`ifdef SNN_LOADER_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          byte_cnt_d   = '0;
          bit_cnt_d    = '0;
          lat_d        = 1'b0;
          result_err_d = 1'b0;
          timeout_d    = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_FETCH: begin
        // img_q carries the pixel addressed in the previous cycle, so the
        // first cycle of a byte has nothing to capture and the latency
        // cycle captures pixel 7.
        if ((bit_cnt_q != 3'd0) || lat_q) begin
          shreg_d = {img_q, shreg_q[7:1]};
        end
        if (lat_q) begin
          lat_d   = 1'b0;
          state_d = S_SEND;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            lat_d = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (tx_rdy) begin
          tx_start_d = 1'b1;
          tx_data_d  = shreg_q;
          state_d    = S_WAIT_ACK;
        end
      end

      // uart_tx may still show ready here; give it a cycle to drop it.
      S_WAIT_ACK: state_d = S_WAIT_TX;

      S_WAIT_TX: begin
        if (tx_rdy) begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d   = S_WAIT_RES;
`ifdef SNN_LOADER_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            byte_cnt_d = byte_cnt_q + 7'd1;
            state_d    = S_FETCH;
          end
        end
      end

      S_WAIT_RES: begin
        // A reply arriving in the expiry cycle still counts.
        if (rx_rdy) begin
          result_d     = rx_data[3:0];
          result_err_d = (rx_data[7:4] != 4'd0) || (rx_data[3:0] > 4'd9);
          done_d       = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_DONE;
        end
`ifdef SNN_LOADER_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      // done/busy were updated on entry so they are visible in this cycle.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      lat_q        <= 1'b0;
      shreg_q      <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      result_err_q <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      lat_q        <= lat_d;
      shreg_q      <= shreg_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      result_err_q <= result_err_d;
      timeout_q    <= timeout_d;
`ifdef SNN_LOADER_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

endmodule
